// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush sequencer for the 5-stage rv32i pipeline.
// It produces the load and flush enables for PC, IF/ID, ID/EX, EX/MEM and
// MEM/WB, arbitrating these events from highest to lowest priority:
// D-cache wait, EX redirect, load-use and I-cache wait. It also owns a
// one-entry fetch buffer and a DRAIN state. DRAIN holds a redirect until the
// I-fetch that is still in flight has returned.
//
// Optional feature: define PIPE_HAZARD_PERF_EN to add saturating counters of
// width PERF_W (perf_dstall, perf_istall, perf_lu, perf_flush).
//
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   imem_resp        I-cache one-cycle response pulse
//   dmem_resp        D-cache one-cycle response pulse
//   mem_read/write   MEM-stage load/store
//   ex_mem_read      EX-stage load
//   ex_rd            EX-stage destination register
//   id_rs1/id_rs2    ID-stage source registers
//   ex_redirect      EX resolved a taken branch/jump to ex_target
//   imem_read        I-cache request
//   load_pc          PC enable; pc_redirect selects pc_target
//   load_if_id       IF/ID enable; flush_if_id loads a NOP
//   ibuf_load        capture the I-cache response into the fetch buffer
//   ibuf_sel         IF/ID takes its source from the fetch buffer
//   load_id_ex       ID/EX enable; flush_id_ex loads a bubble
//   load_ex_mem      EX/MEM enable
//   load_mem_wb      MEM/WB enable
module pipe_hazard_ctrl
`ifdef PIPE_HAZARD_PERF_EN
#(
  parameter int unsigned PERF_W = 32
)
`endif
(
  input  logic        clk,
  input  logic        rst,
  input  logic        imem_resp,
  input  logic        dmem_resp,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic        ex_mem_read,
  input  logic [4:0]  ex_rd,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        ex_redirect,
  input  logic [31:0] ex_target,
  output logic        imem_read,
  output logic        load_pc,
  output logic        pc_redirect,
  output logic [31:0] pc_target,
  output logic        load_if_id,
  output logic        flush_if_id,
  output logic        ibuf_load,
  output logic        ibuf_sel,
  output logic        load_id_ex,
  output logic        flush_id_ex,
  output logic        load_ex_mem,
  output logic        load_mem_wb
`ifdef PIPE_HAZARD_PERF_EN
  ,
  output logic [PERF_W-1:0] perf_dstall,
  output logic [PERF_W-1:0] perf_istall,
  output logic [PERF_W-1:0] perf_lu,
  output logic [PERF_W-1:0] perf_flush
`endif
);

  localparam int unsigned REG_W  = 5;
  localparam int unsigned ADDR_W = 32;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_DRAIN = 1'b1
  } state_e;

  state_e              state_q, state_d;
  // In RUN: a buffered instruction is held. In DRAIN: the in-flight fetch has
  // returned and was discarded, so no new fetch may be issued.
  logic                ibuf_valid_q, ibuf_valid_d;
  logic [ADDR_W-1:0]   tgt_q, tgt_d;

  logic dbusy;
  logic lu;
  logic ifetch;

  // Hazard terms
  assign dbusy  = (mem_read | mem_write) & ~dmem_resp;
  assign lu     = ex_mem_read & (ex_rd != REG_W'(0)) &
                  ((ex_rd == id_rs1) | (ex_rd == id_rs2));
  assign ifetch = ibuf_valid_q | imem_resp;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_RUN;
      ibuf_valid_q <= 1'b0;
      tgt_q        <= '0;
    end else begin
      state_q      <= state_d;
      ibuf_valid_q <= ibuf_valid_d;
      tgt_q        <= tgt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d      = state_q;
    ibuf_valid_d = ibuf_valid_q;
    tgt_d        = tgt_q;
    unique case (state_q)
      ST_RUN: begin
        if (dbusy) begin
          if (imem_resp) ibuf_valid_d = 1'b1;
        end else if (ex_redirect) begin
          if (ifetch) begin
            ibuf_valid_d = 1'b0;
          end else begin
            tgt_d   = ex_target;
            state_d = ST_DRAIN;
          end
        end else if (lu) begin
          if (imem_resp) ibuf_valid_d = 1'b1;
        end else if (ifetch) begin
          ibuf_valid_d = 1'b0;
        end
      end
      ST_DRAIN: begin
        if (ifetch && !dbusy) begin
          state_d      = ST_RUN;
          ibuf_valid_d = 1'b0;
        end else if (imem_resp) begin
          // Response arrived during a D-cache freeze: remember it, drop the data.
          ibuf_valid_d = 1'b1;
        end
      end
    endcase
  end

  // Output logic
  always_comb begin
    imem_read   = ~ibuf_valid_q & ~rst;
    load_pc     = 1'b0;
    pc_redirect = 1'b0;
    pc_target   = (state_q == ST_DRAIN) ? tgt_q : ex_target;
    load_if_id  = 1'b0;
    flush_if_id = 1'b0;
    ibuf_load   = 1'b0;
    ibuf_sel    = 1'b0;
    load_id_ex  = 1'b0;
    flush_id_ex = 1'b0;
    load_ex_mem = 1'b0;
    load_mem_wb = 1'b0;
    if (!rst) begin
      unique case (state_q)
        ST_RUN: begin
          if (dbusy) begin
            ibuf_load = imem_resp;
          end else if (ex_redirect) begin
            load_pc     = ifetch;
            pc_redirect = ifetch;
            load_if_id  = 1'b1;
            flush_if_id = 1'b1;
            load_id_ex  = 1'b1;
            flush_id_ex = 1'b1;
            load_ex_mem = 1'b1;
            load_mem_wb = 1'b1;
          end else if (lu) begin
            ibuf_load   = imem_resp;
            load_id_ex  = 1'b1;
            flush_id_ex = 1'b1;
            load_ex_mem = 1'b1;
            load_mem_wb = 1'b1;
          end else if (!ifetch) begin
            load_if_id  = 1'b1;
            flush_if_id = 1'b1;
            load_id_ex  = 1'b1;
            load_ex_mem = 1'b1;
            load_mem_wb = 1'b1;
          end else begin
            load_pc     = 1'b1;
            load_if_id  = 1'b1;
            ibuf_sel    = ibuf_valid_q;
            load_id_ex  = 1'b1;
            load_ex_mem = 1'b1;
            load_mem_wb = 1'b1;
          end
        end
        ST_DRAIN: begin
          // Front end keeps feeding NOPs; back end freezes on dbusy.
          load_if_id  = 1'b1;
          flush_if_id = 1'b1;
          if (!dbusy) begin
            load_id_ex  = 1'b1;
            flush_id_ex = 1'b1;
            load_ex_mem = 1'b1;
            load_mem_wb = 1'b1;
            load_pc     = ifetch;
            pc_redirect = ifetch;
          end
        end
      endcase
    end
  end

`ifdef PIPE_HAZARD_PERF_EN
  logic run_st;
  assign run_st = (state_q == ST_RUN);

  // Saturating event counters
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_dstall <= '0;
      perf_istall <= '0;
      perf_lu     <= '0;
      perf_flush  <= '0;
    end else begin
      if (dbusy && (perf_dstall != '1))
        perf_dstall <= perf_dstall + PERF_W'(1);
      if (run_st && !ifetch && (perf_istall != '1))
        perf_istall <= perf_istall + PERF_W'(1);
      if (run_st && !dbusy && !ex_redirect && lu && (perf_lu != '1))
        perf_lu <= perf_lu + PERF_W'(1);
      if (run_st && !dbusy && ex_redirect && (perf_flush != '1))
        perf_flush <= perf_flush + PERF_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed vectors with literal
// expectations plus a per-cycle comparison against a rule-table model.
module tb_pipe_hazard_ctrl;

  logic        clk;
  logic        rst;
  logic        imem_resp, dmem_resp, mem_read, mem_write, ex_mem_read;
  logic [4:0]  ex_rd, id_rs1, id_rs2;
  logic        ex_redirect;
  logic [31:0] ex_target;
  logic        imem_read, load_pc, pc_redirect;
  logic [31:0] pc_target;
  logic        load_if_id, flush_if_id, ibuf_load, ibuf_sel;
  logic        load_id_ex, flush_id_ex, load_ex_mem, load_mem_wb;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  pipe_hazard_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .imem_resp   (imem_resp),
    .dmem_resp   (dmem_resp),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .ex_mem_read (ex_mem_read),
    .ex_rd       (ex_rd),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .ex_redirect (ex_redirect),
    .ex_target   (ex_target),
    .imem_read   (imem_read),
    .load_pc     (load_pc),
    .pc_redirect (pc_redirect),
    .pc_target   (pc_target),
    .load_if_id  (load_if_id),
    .flush_if_id (flush_if_id),
    .ibuf_load   (ibuf_load),
    .ibuf_sel    (ibuf_sel),
    .load_id_ex  (load_id_ex),
    .flush_id_ex (flush_id_ex),
    .load_ex_mem (load_ex_mem),
    .load_mem_wb (load_mem_wb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, got, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Model state: pending redirect, buffered/returned fetch, latched target.
  bit          m_drain = 1'b0, m_buf = 1'b0;
  logic [31:0] m_tgt = '0;
  bit          nx_drain = 1'b0, nx_buf = 1'b0;
  logic [31:0] nx_tgt = '0;

  typedef enum int {R_RESET, R_FREEZE, R_REDIR_HIT, R_REDIR_MISS, R_LU,
                    R_STARVE, R_RUN, R_DR_FROZEN, R_DR_BUB, R_DR_EXIT} rule_e;

  // Enable vector order: load_pc,pc_redirect,load_if_id,flush_if_id,
  //                      load_id_ex,flush_id_ex,load_ex_mem,load_mem_wb
  always @(negedge clk) begin
    if (chk_en) begin
      bit mem_busy, hazard, have_insn;
      rule_e r;
      logic [7:0] e_en;
      bit e_il, e_isel;
      mem_busy  = (mem_read || mem_write) && !dmem_resp;
      hazard    = ex_mem_read && (ex_rd != 5'd0) && (ex_rd == id_rs1 || ex_rd == id_rs2);
      have_insn = m_buf || imem_resp;
      if (rst)                 r = R_RESET;
      else if (m_drain) begin
        if (mem_busy)          r = R_DR_FROZEN;
        else if (have_insn)    r = R_DR_EXIT;
        else                   r = R_DR_BUB;
      end
      else if (mem_busy)       r = R_FREEZE;
      else if (ex_redirect)    r = have_insn ? R_REDIR_HIT : R_REDIR_MISS;
      else if (hazard)         r = R_LU;
      else if (!have_insn)     r = R_STARVE;
      else                     r = R_RUN;

      e_il = 1'b0; e_isel = 1'b0;
      nx_drain = m_drain; nx_buf = m_buf; nx_tgt = m_tgt;
      case (r)
        R_RESET:      begin e_en = 8'b0000_0000; nx_drain = 0; nx_buf = 0; nx_tgt = '0; end
        R_FREEZE:     begin e_en = 8'b0000_0000; e_il = imem_resp; nx_buf = m_buf | imem_resp; end
        R_REDIR_HIT:  begin e_en = 8'b1111_1111; nx_buf = 0; end
        R_REDIR_MISS: begin e_en = 8'b0011_1111; nx_drain = 1; nx_tgt = ex_target; end
        R_LU:         begin e_en = 8'b0000_1111; e_il = imem_resp; nx_buf = m_buf | imem_resp; end
        R_STARVE:     begin e_en = 8'b0011_1011; end
        R_RUN:        begin e_en = 8'b1010_1011; e_isel = m_buf; nx_buf = 0; end
        R_DR_FROZEN:  begin e_en = 8'b0011_0000; nx_buf = m_buf | imem_resp; end
        R_DR_BUB:     begin e_en = 8'b0011_1111; end
        default:      begin e_en = 8'b1111_1111; nx_drain = 0; nx_buf = 0; end
      endcase

      check("m_enables", {24'd0, load_pc, pc_redirect, load_if_id, flush_if_id,
                          load_id_ex, flush_id_ex, load_ex_mem, load_mem_wb}, {24'd0, e_en});
      check("m_imem_read", {31'd0, imem_read}, {31'd0, !m_buf && !rst});
      check("m_ibuf_load", {31'd0, ibuf_load}, {31'd0, e_il});
      check("m_ibuf_sel",  {31'd0, ibuf_sel},  {31'd0, e_isel});
      if (e_en[6])
        check("m_pc_target", pc_target, (r == R_DR_EXIT) ? m_tgt : ex_target);
    end
  end

  always @(posedge clk) begin
    m_drain <= nx_drain;
    m_buf   <= nx_buf;
    m_tgt   <= nx_tgt;
  end

  // ---------------- stimulus helpers ----------------
  task automatic idle();
    imem_resp = 0; dmem_resp = 0; mem_read = 0; mem_write = 0; ex_mem_read = 0;
    ex_rd = 0; id_rs1 = 0; id_rs2 = 0; ex_redirect = 0; ex_target = 32'h0;
  endtask

  task automatic settle();
    #3;
  endtask

  task automatic next();
    @(posedge clk); #1;
  endtask

  task automatic lit(input string nm, input logic got, input logic exp);
    check(nm, {31'd0, got}, {31'd0, exp});
  endtask

  initial begin
    rst = 1'b1;
    idle();
    @(posedge clk); #1;
    chk_en = 1'b1;

    // Reset: everything off
    settle();
    lit("rst_load_pc", load_pc, 0);
    lit("rst_imem_read", imem_read, 0);
    lit("rst_flush_if_id", flush_if_id, 0);
    next();
    rst = 1'b0; idle();
    settle();
    lit("starve_imem_read", imem_read, 1);
    lit("starve_load_pc", load_pc, 0);
    lit("starve_flush_if_id", flush_if_id, 1);

    // Load-use: lw x5 in EX, add x6,x5,x1 in ID
    next(); idle(); imem_resp = 1; ex_mem_read = 1; ex_rd = 5; id_rs1 = 5; id_rs2 = 1;
    settle();
    lit("lu_flush_id_ex", flush_id_ex, 1);
    lit("lu_load_pc", load_pc, 0);
    lit("lu_load_if_id", load_if_id, 0);
    lit("lu_ibuf_load", ibuf_load, 1);
    next(); idle(); ex_rd = 6; id_rs1 = 7;
    settle();
    lit("lu_after_flush_id_ex", flush_id_ex, 0);
    lit("lu_after_ibuf_sel", ibuf_sel, 1);
    lit("lu_after_load_pc", load_pc, 1);
    // ex_rd = x0: no bubble
    next(); idle(); imem_resp = 1; ex_mem_read = 1; ex_rd = 0; id_rs1 = 0;
    settle();
    lit("lu_x0_flush_id_ex", flush_id_ex, 0);
    lit("lu_x0_load_pc", load_pc, 1);

    // Store freeze 4 cycles, I-cache response in cycle 2
    for (int i = 0; i < 4; i++) begin
      next(); idle(); mem_write = 1; imem_resp = (i == 1);
      settle();
      lit("frz_load_pc", load_pc, 0);
      lit("frz_load_mem_wb", load_mem_wb, 0);
      if (i == 1) lit("frz_ibuf_load", ibuf_load, 1);
      if (i == 2) lit("frz_imem_read", imem_read, 0);
    end
    next(); idle(); mem_write = 1; dmem_resp = 1;
    settle();
    lit("frz_rel_ibuf_sel", ibuf_sel, 1);
    lit("frz_rel_load_mem_wb", load_mem_wb, 1);
    lit("frz_rel_load_pc", load_pc, 1);

    // Taken branch with fetch returning same cycle
    next(); idle(); ex_redirect = 1; ex_target = 32'h60; imem_resp = 1;
    settle();
    lit("bhit_pc_redirect", pc_redirect, 1);
    check("bhit_pc_target", pc_target, 32'h60);
    lit("bhit_flush_if_id", flush_if_id, 1);
    lit("bhit_flush_id_ex", flush_id_ex, 1);
    next(); idle(); imem_resp = 1;
    settle();
    lit("bhit_after_pc_redirect", pc_redirect, 0);

    // Taken branch to 0x80 with fetch outstanding, response 3 cycles later
    next(); idle(); ex_redirect = 1; ex_target = 32'h80;
    settle();
    lit("bmiss_load_pc", load_pc, 0);
    lit("bmiss_flush_if_id", flush_if_id, 1);
    lit("bmiss_flush_id_ex", flush_id_ex, 1);
    for (int i = 0; i < 3; i++) begin
      next(); idle(); ex_target = 32'h1234; imem_resp = (i == 2);
      settle();
      lit("drain_flush_if_id", flush_if_id, 1);
      lit("drain_ibuf_load", ibuf_load, 0);
      lit("drain_pc_redirect", pc_redirect, i == 2);
      if (i == 2) check("drain_pc_target", pc_target, 32'h80);
    end
    next(); idle();
    settle();
    lit("drain_done_flush_id_ex", flush_id_ex, 0);
    lit("drain_done_imem_read", imem_read, 1);

    // Redirect pending while D-cache busy: response discarded, exit on dmem_resp
    next(); idle(); ex_redirect = 1; ex_target = 32'h100;
    next(); idle(); mem_read = 1; imem_resp = 1;
    settle();
    lit("drfz_ibuf_load", ibuf_load, 0);
    lit("drfz_load_ex_mem", load_ex_mem, 0);
    lit("drfz_load_pc", load_pc, 0);
    next(); idle(); mem_read = 1;
    settle();
    lit("drfz_imem_read", imem_read, 0);
    lit("drfz_hold_load_pc", load_pc, 0);
    next(); idle(); mem_read = 1; dmem_resp = 1;
    settle();
    lit("drfz_exit_pc_redirect", pc_redirect, 1);
    check("drfz_exit_pc_target", pc_target, 32'h100);
    next(); idle();
    settle();
    lit("drfz_after_imem_read", imem_read, 1);

    // Redirect and load-use together: redirect wins
    next(); idle(); ex_redirect = 1; ex_target = 32'h40; imem_resp = 1;
    ex_mem_read = 1; ex_rd = 7; id_rs2 = 7;
    settle();
    lit("both_load_pc", load_pc, 1);
    lit("both_pc_redirect", pc_redirect, 1);
    lit("both_load_if_id", load_if_id, 1);
    lit("both_flush_if_id", flush_if_id, 1);
    check("both_pc_target", pc_target, 32'h40);
    next(); idle(); imem_resp = 1;

    // Reset in DRAIN with a returned fetch recorded
    next(); idle(); ex_redirect = 1; ex_target = 32'h200;
    next(); idle(); mem_read = 1; imem_resp = 1;
    next(); idle(); rst = 1;
    settle();
    lit("rstd_imem_read", imem_read, 0);
    lit("rstd_load_pc", load_pc, 0);
    lit("rstd_flush_if_id", flush_if_id, 0);
    lit("rstd_load_mem_wb", load_mem_wb, 0);
    next(); rst = 0; idle();
    settle();
    lit("rstd_rel_imem_read", imem_read, 1);
    lit("rstd_rel_flush_id_ex", flush_id_ex, 0);
    lit("rstd_rel_pc_redirect", pc_redirect, 0);
    next(); idle(); imem_resp = 1;
    settle();
    lit("rstd_run_load_pc", load_pc, 1);
    lit("rstd_run_pc_redirect", pc_redirect, 0);

    next(); idle();
    next(); idle();
    @(posedge clk);
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
